// File: rtl/update_monitor.sv
// Receiver for the chip-enable / update-toggle protocol: turns each toggle into a
// sequence-numbered event, queues it for a valid/ready consumer, flags protocol errors and stalls.
module update_monitor #(
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_enable,
    input  logic             update_stat,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_seq,
    output logic [CNT_W-1:0] update_cnt,
    output logic [7:0]       drop_cnt,
    output logic             proto_err,
    output logic             stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(TIMEOUT);

    // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
    // evt_seq is stable while evt_valid is high and the head has not been accepted.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STUCK = 2'd2
    } wd_state_t;

    logic             stat_q;
    logic             ce_q;
    logic             toggle;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    wd_state_t        state;
    wd_state_t        state_nxt;
    logic [SW-1:0]    stall_cnt;
    logic [SW-1:0]    stall_cnt_nxt;

    assign toggle    = update_stat ^ stat_q;
    assign full      = (count == CW'(DEPTH));
    assign evt_valid = (count != '0);
    assign evt_seq   = mem[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    // A full queue still takes the new event when the head leaves in the same cycle.
    assign push      = toggle && (!full || pop);
    assign drop      = toggle && full && !pop;
    assign stall     = (state == ST_STUCK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            stat_q <= update_stat;
            ce_q   <= chip_enable;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_cnt <= '0;
            drop_cnt   <= '0;
            proto_err  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            update_cnt <= '0;
            drop_cnt   <= '0;
            proto_err  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (toggle) begin
                update_cnt <= update_cnt + CNT_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= update_cnt;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            // Spurious toggle (enable was low) or missed toggle (enable was high).
            if ((toggle && !ce_q) || (ce_q && !toggle)) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        if (clear) begin
            state_nxt     = ST_IDLE;
            stall_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt_nxt = '0;
                    if (ce_q) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ce_q) begin
                        state_nxt     = ST_IDLE;
                        stall_cnt_nxt = '0;
                    end else if (toggle) begin
                        stall_cnt_nxt = '0;
                    end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
                        state_nxt = ST_STUCK;
                    end else begin
                        stall_cnt_nxt = stall_cnt + SW'(1);
                    end
                end
                ST_STUCK: begin
                    if (!ce_q) begin
                        state_nxt     = ST_IDLE;
                        stall_cnt_nxt = '0;
                    end else if (toggle) begin
                        state_nxt     = ST_RUN;
                        stall_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    stall_cnt_nxt = '0;
                end
            endcase
        end
    end
endmodule

// File: doc/update_monitor.md
Name: update_monitor

Overview:
- Receiving end of the chip-enable / update-toggle protocol.
- Samples the toggling `update_stat` line together with `chip_enable`.
- Converts each toggle into a discrete, sequence-numbered update event and queues events for a downstream consumer over a valid/ready handshake.
- Flags protocol violations and detects stuck (non-toggling) operation with a watchdog.

Parameters:
- CNT_W, 16, width of update counter and event sequence numbers
- DEPTH, 4, event queue depth; power of 2, at least 2
- TIMEOUT, 64, consecutive enabled cycles without a toggle before stall is asserted; at least 2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- chip_enable  in  1  enable from the update source
- update_stat  in  1  toggle line; each change is one update
- clear  in  1  synchronous clear of counters, queue, flags and watchdog
- evt_valid  out  1  queue head valid
- evt_ready  in  1  consumer accepts head
- evt_seq  out  CNT_W  sequence number at queue head
- update_cnt  out  CNT_W  total updates seen, wraps
- drop_cnt  out  8  events lost to full queue, saturates at 255
- proto_err  out  1  sticky protocol error
- stall  out  1  watchdog stuck indication

Behaviour:
- Reset (rst=0, async): stat_q=0, ce_q=0, update_cnt=0, drop_cnt=0, queue empty, evt_valid=0, evt_seq=0, proto_err=0, stall=0, FSM=IDLE, stall_cnt=0.
- Sampling:
  - stat_q<=update_stat and ce_q<=chip_enable every cycle.
  - toggle = update_stat ^ stat_q, combinational.
  - The source toggles on the edge where its enable is high, so a valid toggle pairs with ce_q=1.
- Update count: on toggle, update_cnt<=update_cnt+1 (mod 2^CNT_W). The event's seq is the pre-increment value, so the first update has seq 0.
- Protocol check: proto_err<=1 when (toggle && !ce_q), a spurious toggle, or (ce_q && !toggle), a missed toggle. It stays high until clear or reset.
- Queue:
  - Circular buffer of DEPTH entries with wrapping read/write pointers and a count.
  - Push on toggle when not full.
  - Pop when evt_valid && evt_ready.
  - evt_valid = count!=0; evt_seq = entry at read pointer, registered-array read with no bubble.
  - Full, push and pop in the same cycle: both occur, count unchanged, event accepted.
  - Full, push only: event dropped, drop_cnt saturating +1, update_cnt still increments.
  - Empty, pop and push in the same cycle: pop is ignored because evt_valid=0; push is taken. The new event is visible next cycle.
- Watchdog FSM:
  - IDLE: ce_q=0; stall_cnt held at 0. Go to RUN when ce_q=1.
  - RUN:
    - Toggle: stall_cnt<=0.
    - No toggle: stall_cnt+1. When stall_cnt reaches TIMEOUT-1 with no toggle, go to STUCK.
    - ce_q=0: go to IDLE.
  - STUCK: stall=1. Toggle → RUN with stall_cnt=0. ce_q=0 → IDLE. Either way stall drops the next cycle.
  - stall = (state==STUCK), registered.
- clear (synchronous):
  - Zeroes update_cnt, drop_cnt and proto_err, empties the queue, sets FSM=IDLE and stall_cnt=0.
  - Does not affect stat_q or ce_q.
  - Takes priority over a same-cycle toggle: that event is not counted, queued or error-checked.
- Reset asserted mid-operation discards all queued events immediately. After release, the first sampled update_stat compares against stat_q=0.

Test Plan:
- Reset then chip_enable=1 with update_stat toggling every cycle for 3 cycles, evt_ready=1 → three events with evt_seq 0, 1, 2; update_cnt=3; proto_err=0; stall=0.
- evt_ready=0 with DEPTH=4 and 6 toggles → evt_valid=1, update_cnt=6, drop_cnt=2. Then evt_ready=1 → seq 0, 1, 2, 3 drain in order and evt_valid then falls.
- Full queue with a simultaneous toggle and pop → count stays 4, drop_cnt unchanged, new seq 4 appears after seq 3.
- Toggle while chip_enable was low the prior cycle → proto_err=1 and it persists. Pulse clear → proto_err=0, update_cnt=0, queue empty.
- chip_enable=1 with update_stat frozen, TIMEOUT=64 → stall=1 after 64 enabled cycles and proto_err=1. One toggle → stall=0 next cycle.
- With CNT_W=4, 17 toggles → update_cnt wraps to 1 and evt_seq sequence wraps 15→0. Assert rst mid-burst → evt_valid=0 and all counters 0 immediately.
